miriscv_timer: RTL and testbench
================================

MIRISCV_TIMER -- requirements
Module: miriscv_timer

Interface
REQ-001 Parameter PRESCALE_W, default 16: width of the PRESCALE register and the prescaler counter.
REQ-002 Parameter RESET_LOAD, default 32'h0: reset value of LOAD and COUNT.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 req_i  input  1  data-bus request from the address decoder (this block selected).
REQ-006 we_i  input  1  1 = write, 0 = read; valid with req_i.
REQ-007 be_i  input  4  byte enables for writes; be_i[n] qualifies wdata_i[8n+7:8n].
REQ-008 addr_i  input  32  byte address; only addr_i[4:2] decoded.
REQ-009 wdata_i  input  32  write data.
REQ-010 rdata_o  output  32  read data, registered.
REQ-011 int_req_o  output  1  interrupt request, one line of the interrupt controller's int_req vector.
REQ-012 int_fin_i  input  1  interrupt-finished pulse from the interrupt controller for this line.

Function
REQ-013 Register map by addr_i[4:2]: 0 CTRL, 1 LOAD, 2 COUNT, 3 PRESCALE, 4 STATUS; indices 5-7 read 0, writes ignored.
REQ-014 CTRL bits: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; bits [31:3] read 0.
REQ-015 STATUS bit [0] PENDING; write-1-to-clear; bits [31:1] read 0.
REQ-016 Write = req_i & we_i; each byte updates only when its be_i bit is 1.
REQ-017 Read = req_i & ~we_i; rdata_o holds the addressed register value one cycle later (latency 1); rdata_o otherwise holds its last value.
REQ-018 Writing LOAD copies the merged LOAD value into COUNT in the same edge and clears the prescaler.
REQ-019 Prescaler: when EN=1 it counts 0..PRESCALE; tick asserts in the cycle it equals PRESCALE, then it wraps to 0; PRESCALE=0 ticks every cycle.
REQ-020 When EN=0, prescaler and COUNT hold.
REQ-021 On tick with COUNT!=0: COUNT decrements by 1.
REQ-022 On tick with COUNT==0 (underflow): if AUTO_RELOAD=1, COUNT<=LOAD; else COUNT stays 0 and EN clears.
REQ-023 Underflow sets PENDING regardless of IRQ_EN.
REQ-024 int_req_o = PENDING & IRQ_EN, combinational from registers.
REQ-025 PENDING clears on int_fin_i=1 or a STATUS write with wdata_i[0]=1 and be_i[0]=1.
REQ-026 Underflow and a clear in the same cycle: PENDING stays set.
REQ-027 A software write to COUNT or CTRL in the same cycle as a tick overrides the tick's update of that register.
REQ-028 COUNT arithmetic is 32-bit unsigned; no wrap below 0.

Reset
REQ-029 On rst_i=1 at a clock edge: CTRL=0, PRESCALE=0, prescaler=0, PENDING=0, LOAD=COUNT=RESET_LOAD, rdata_o=0, so int_req_o=0.
REQ-030 Reset during counting or with PENDING set aborts all activity; the next cycle behaves as the cycle after power-up.

Structure
REQ-031 Package miriscv_timer_pkg holds register-index constants and CTRL/STATUS bit positions, shared with the address decoder and software headers.
REQ-032 Sub-module miriscv_timer_prescaler (inputs en, limit, clear; output tick) implements REQ-019/020.

Verification
REQ-033 PRESCALE=0, LOAD=3, CTRL=3'b111 -> COUNT 3,2,1,0 then reload to 3; int_req_o rises in the cycle after the underflow tick; the underflow recurs every 4 cycles.
REQ-034 PRESCALE=2, LOAD=1, CTRL=3'b101 (one-shot) -> COUNT decrements every 3 cycles, underflow sets PENDING, EN reads 0, COUNT holds 0.
REQ-035 Write LOAD=32'hAABBCCDD with be_i=4'b0101 over LOAD=0 -> LOAD=COUNT=32'h00BB00DD; read of index 1 returns it one cycle later.
REQ-036 PENDING=1, IRQ_EN=1, int_fin_i pulse -> int_req_o=0 next cycle; int_fin_i coincident with underflow -> PENDING stays 1.
REQ-037 rst_i asserted mid-count with int_req_o=1 -> next cycle all registers at reset values, int_req_o=0; read of index 6 returns 0.

Source files
------------

// File: rtl/miriscv_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_timer_pkg
// Brief   : Register indices, CTRL/STATUS bit positions and helpers shared by
//           the timer, the address decoder and the software headers.
// Revision: 1.0 - initial release
// ============================================================================
package miriscv_timer_pkg;

    // Register index, taken from addr[4:2]
    localparam logic [2:0] c_IDX_CTRL     = 3'd0;
    localparam logic [2:0] c_IDX_LOAD     = 3'd1;
    localparam logic [2:0] c_IDX_COUNT    = 3'd2;
    localparam logic [2:0] c_IDX_PRESCALE = 3'd3;
    localparam logic [2:0] c_IDX_STATUS   = 3'd4;

    // CTRL bit positions
    localparam int unsigned c_CTRL_EN          = 0;
    localparam int unsigned c_CTRL_AUTO_RELOAD = 1;
    localparam int unsigned c_CTRL_IRQ_EN      = 2;
    localparam int unsigned c_CTRL_W           = 3;

    // STATUS bit positions
    localparam int unsigned c_STATUS_PENDING   = 0;

    // CTRL register layout; member order matches the bit positions above
    typedef struct packed {
        logic irq_en;       // [2]
        logic auto_reload;  // [1]
        logic en;           // [0]
    } ctrl_t;

    // Replace each byte of old_val whose enable is set with the new byte
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_timer_if.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_timer_if
// Brief   : Data-bus slave port of the timer (request, write strobe, byte
//           enables, address, write data and registered read data).
// Revision: 1.0 - initial release
// ============================================================================
interface miriscv_timer_if;

    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    // Bus side (core / decoder)
    modport master (
        output req_i,
        output we_i,
        output be_i,
        output addr_i,
        output wdata_i,
        input  rdata_o
    );

    // Timer side
    modport slave (
        input  req_i,
        input  we_i,
        input  be_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o
    );

endinterface
`default_nettype wire

// File: rtl/miriscv_timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_timer_prescaler
// Brief   : Free-running divider; counts 0..limit while enabled and emits a
//           one-cycle tick on the cycle it equals limit, then wraps to 0.
// Revision: 1.0 - initial release
// ============================================================================
module miriscv_timer_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  en,
    input  wire logic [PRESCALE_W-1:0] limit,
    input  wire logic                  clear,
    output logic                       tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // A limit of 0 makes every enabled cycle a tick
    assign tick = en & (cnt_q == limit);

    // Next count: clear wins, otherwise advance/wrap only while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/miriscv_timer.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_timer
// Brief   : Memory-mapped down-counting timer with prescaler, one-shot or
//           auto-reload mode and a level interrupt request.
// Revision: 1.0 - initial release
// ============================================================================
module miriscv_timer
    import miriscv_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [31:0] RESET_LOAD = 32'h0
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    miriscv_timer_if.slave    bus,
    output logic              int_req_o,
    input  wire logic         int_fin_i
);

    // Architectural state
    ctrl_t                 ctrl_q,     ctrl_d;
    logic [31:0]           load_q,     load_d;
    logic [31:0]           count_q,    count_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  pending_q,  pending_d;
    logic [31:0]           rdata_q,    rdata_d;

    logic                  w_wr;
    logic                  w_rd;
    logic [2:0]            w_idx;
    logic                  w_tick;
    logic                  w_underflow;
    logic                  w_psc_clear;
    logic                  w_pending_clr;
    logic [31:0]           w_rdata_sel;
    logic                  unused_addr;

    assign w_wr  = bus.req_i & bus.we_i;
    assign w_rd  = bus.req_i & ~bus.we_i;
    assign w_idx = bus.addr_i[4:2];

    // Only word index bits take part in decoding
    assign unused_addr = ^{bus.addr_i[31:5], bus.addr_i[1:0]};

    // Prescaler; a LOAD write restarts the prescale period
    miriscv_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (ctrl_q.en),
        .limit (prescale_q),
        .clear (w_psc_clear),
        .tick  (w_tick)
    );

    assign w_underflow = w_tick & (count_q == 32'd0);

    // Read multiplexer over the current register contents
    always_comb begin
        w_rdata_sel = 32'd0;
        case (w_idx)
            c_IDX_CTRL:     w_rdata_sel = 32'(ctrl_q);
            c_IDX_LOAD:     w_rdata_sel = load_q;
            c_IDX_COUNT:    w_rdata_sel = count_q;
            c_IDX_PRESCALE: w_rdata_sel = 32'(prescale_q);
            c_IDX_STATUS:   w_rdata_sel = {31'd0, pending_q};
            default:        w_rdata_sel = 32'd0;
        endcase
    end

    // Next-state: counter update on tick first, software writes override it
    always_comb begin
        ctrl_d        = ctrl_q;
        load_d        = load_q;
        count_d       = count_q;
        prescale_d    = prescale_q;
        rdata_d       = rdata_q;
        w_psc_clear   = 1'b0;
        w_pending_clr = int_fin_i;

        if (w_tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q.auto_reload) begin
                count_d = load_q;
            end else begin
                ctrl_d.en = 1'b0;   // one-shot: stop with COUNT parked at 0
            end
        end

        if (w_wr) begin
            case (w_idx)
                c_IDX_CTRL: begin
                    if (bus.be_i[0]) begin
                        ctrl_d = ctrl_t'(bus.wdata_i[c_CTRL_W-1:0]);
                    end
                end
                c_IDX_LOAD: begin
                    load_d      = byte_merge(load_q, bus.wdata_i, bus.be_i);
                    count_d     = load_d;
                    w_psc_clear = 1'b1;
                end
                c_IDX_COUNT: begin
                    count_d = byte_merge(count_q, bus.wdata_i, bus.be_i);
                end
                c_IDX_PRESCALE: begin
                    prescale_d = PRESCALE_W'(byte_merge(32'(prescale_q),
                                                        bus.wdata_i, bus.be_i));
                end
                c_IDX_STATUS: begin
                    if (bus.be_i[0] && bus.wdata_i[c_STATUS_PENDING]) begin
                        w_pending_clr = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // A new underflow beats any clear arriving in the same cycle
        pending_d = w_underflow | (pending_q & ~w_pending_clr);

        if (w_rd) begin
            rdata_d = w_rdata_sel;
        end
    end

    // Register bank
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            load_q     <= RESET_LOAD;
            count_q    <= RESET_LOAD;
            prescale_q <= '0;
            pending_q  <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            pending_q  <= pending_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign int_req_o   = pending_q & ctrl_q.irq_en;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_miriscv_timer
// Brief   : Self-checking bench for miriscv_timer: directed scenarios with
//           fixed expectations followed by random bus traffic compared with a
//           cycle-level reference model of the register behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_miriscv_timer;
    import miriscv_timer_pkg::*;

    localparam logic [31:0] TB_RESET_LOAD = 32'h0000_0005;
    localparam int unsigned TB_PW         = 16;

    logic clk;
    logic rst_i;
    logic int_req_o;
    logic int_fin_i;

    miriscv_timer_if bus ();

    miriscv_timer #(
        .PRESCALE_W (TB_PW),
        .RESET_LOAD (TB_RESET_LOAD)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bus.slave),
        .int_req_o (int_req_o),
        .int_fin_i (int_fin_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [2:0]       m_ctrl;
    logic [31:0]      m_load;
    logic [31:0]      m_count;
    logic [TB_PW-1:0] m_prescale;
    logic [TB_PW-1:0] m_psc;
    logic             m_pending;
    logic [31:0]      m_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // One clock edge of the timer as described by its register rules
    task automatic model_edge(input logic rst, input logic req, input logic we,
                              input logic [2:0] idx, input logic [3:0] be,
                              input logic [31:0] wd, input logic fin);
        logic        tick, uf, clr, wr, rd;
        logic [31:0] mask, rv, tmp;
        logic [2:0]  n_ctrl;
        logic [31:0] n_load, n_count;
        logic [TB_PW-1:0] n_prescale, n_psc;
        if (rst) begin
            m_ctrl = 3'd0; m_load = TB_RESET_LOAD; m_count = TB_RESET_LOAD;
            m_prescale = '0; m_psc = '0; m_pending = 1'b0; m_rdata = 32'd0;
            return;
        end
        wr   = req & we;
        rd   = req & ~we;
        mask = be_mask(be);
        case (idx)
            3'd0:    rv = {29'd0, m_ctrl};
            3'd1:    rv = m_load;
            3'd2:    rv = m_count;
            3'd3:    rv = 32'(m_prescale);
            3'd4:    rv = {31'd0, m_pending};
            default: rv = 32'd0;
        endcase
        tick = m_ctrl[0] && (m_psc == m_prescale);
        uf   = tick && (m_count == 32'd0);
        n_ctrl = m_ctrl; n_load = m_load; n_count = m_count; n_prescale = m_prescale;
        n_psc  = m_ctrl[0] ? (tick ? '0 : m_psc + 1'b1) : m_psc;
        if (tick) begin
            if (m_count != 0)    n_count = m_count - 1;
            else if (m_ctrl[1])  n_count = m_load;
            else                 n_ctrl[0] = 1'b0;
        end
        clr = fin;
        if (wr) begin
            case (idx)
                3'd0: if (be[0]) n_ctrl = wd[2:0];
                3'd1: begin
                    n_load = (m_load & ~mask) | (wd & mask);
                    n_count = n_load;
                    n_psc = '0;
                end
                3'd2: n_count = (m_count & ~mask) | (wd & mask);
                3'd3: begin
                    tmp = (32'(m_prescale) & ~mask) | (wd & mask);
                    n_prescale = tmp[TB_PW-1:0];
                end
                3'd4: if (be[0] && wd[0]) clr = 1'b1;
                default: ;
            endcase
        end
        m_pending  = uf | (m_pending & ~clr);
        m_ctrl     = n_ctrl; m_load = n_load; m_count = n_count;
        m_prescale = n_prescale; m_psc = n_psc;
        if (rd) m_rdata = rv;
    endtask

    // Drive one cycle, advance the model, then compare outputs after the edge
    task automatic step(input logic rst, input logic req, input logic we,
                        input logic [2:0] idx, input logic [3:0] be,
                        input logic [31:0] wd, input logic fin);
        logic [31:0] a;
        a = $urandom();
        a[4:2] = idx;
        rst_i = rst; bus.req_i = req; bus.we_i = we; bus.be_i = be;
        bus.addr_i = a; bus.wdata_i = wd; int_fin_i = fin;
        @(posedge clk);
        model_edge(rst, req, we, idx, be, wd, fin);
        #1;
        check("model_rdata", bus.rdata_o, m_rdata);
        check("model_int_req", 32'(int_req_o), 32'(m_pending & m_ctrl[2]));
    endtask

    task automatic wr(input logic [2:0] idx, input logic [3:0] be, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, idx, be, d, 1'b0);
    endtask
    task automatic rd(input logic [2:0] idx);
        step(1'b0, 1'b1, 1'b0, idx, 4'h0, 32'd0, 1'b0);
    endtask
    task automatic idle(input logic fin);
        step(1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 32'd0, fin);
    endtask
    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] exp_cnt [5];
        int          r;
        logic        s_rst, s_req, s_we, s_fin;
        logic [2:0]  s_idx;
        logic [3:0]  s_be;
        logic [31:0] s_wd;

        rst_i = 1'b1; int_fin_i = 1'b0;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0;
        bus.addr_i = 32'd0; bus.wdata_i = 32'd0;

        // Reset state
        do_reset();
        do_reset();
        check("rst_int_req", 32'(int_req_o), 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        rd(c_IDX_CTRL);     check("rst_ctrl", bus.rdata_o, 32'd0);
        rd(c_IDX_LOAD);     check("rst_load", bus.rdata_o, TB_RESET_LOAD);
        rd(c_IDX_COUNT);    check("rst_count", bus.rdata_o, TB_RESET_LOAD);
        rd(c_IDX_PRESCALE); check("rst_prescale", bus.rdata_o, 32'd0);
        rd(c_IDX_STATUS);   check("rst_status", bus.rdata_o, 32'd0);

        // Auto-reload, PRESCALE=0: COUNT 3,2,1,0,3 and interrupt after underflow
        wr(c_IDX_PRESCALE, 4'hF, 32'd0);
        wr(c_IDX_LOAD, 4'hF, 32'd3);
        wr(c_IDX_CTRL, 4'hF, 32'h7);
        exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
        for (int i = 0; i < 5; i++) begin
            rd(c_IDX_COUNT);
            check("ar_count", bus.rdata_o, exp_cnt[i]);
            check("ar_int_req", 32'(int_req_o), (i >= 3) ? 32'd1 : 32'd0);
        end
        // int_fin clears; then int_fin coincident with the next underflow
        idle(1'b1); check("fin_clears", 32'(int_req_o), 32'd0);
        idle(1'b0); check("fin_stays_clear", 32'(int_req_o), 32'd0);
        idle(1'b1); check("fin_vs_underflow", 32'(int_req_o), 32'd1);

        // Reset mid-count with interrupt asserted
        do_reset();
        check("midrst_int_req", 32'(int_req_o), 32'd0);
        check("midrst_rdata", bus.rdata_o, 32'd0);
        rd(c_IDX_CTRL);   check("midrst_ctrl", bus.rdata_o, 32'd0);
        rd(c_IDX_COUNT);  check("midrst_count", bus.rdata_o, TB_RESET_LOAD);
        rd(c_IDX_STATUS); check("midrst_status", bus.rdata_o, 32'd0);
        rd(3'd6);         check("idx6_read", bus.rdata_o, 32'd0);

        // One-shot with PRESCALE=2
        wr(c_IDX_PRESCALE, 4'hF, 32'd2);
        wr(c_IDX_LOAD, 4'hF, 32'd1);
        wr(c_IDX_CTRL, 4'hF, 32'h5);
        idle(1'b0);
        idle(1'b0);
        rd(c_IDX_COUNT); check("os_count_before", bus.rdata_o, 32'd1);
        rd(c_IDX_COUNT); check("os_count_after", bus.rdata_o, 32'd0);
        idle(1'b0);      check("os_no_irq_yet", 32'(int_req_o), 32'd0);
        idle(1'b0);      check("os_irq", 32'(int_req_o), 32'd1);
        rd(c_IDX_CTRL);  check("os_en_cleared", bus.rdata_o, 32'h4);
        rd(c_IDX_COUNT); check("os_count_held", bus.rdata_o, 32'd0);
        rd(c_IDX_STATUS); check("os_pending", bus.rdata_o, 32'd1);
        wr(c_IDX_STATUS, 4'hE, 32'hFFFF_FFFF);
        rd(c_IDX_STATUS); check("w1c_needs_be0", bus.rdata_o, 32'd1);
        wr(c_IDX_STATUS, 4'h1, 32'h1);
        check("w1c_int_req", 32'(int_req_o), 32'd0);
        rd(c_IDX_STATUS); check("w1c_cleared", bus.rdata_o, 32'd0);

        // Byte-enable merge on LOAD
        wr(c_IDX_LOAD, 4'hF, 32'd0);
        wr(c_IDX_LOAD, 4'b0101, 32'hAABB_CCDD);
        rd(c_IDX_LOAD);  check("be_load", bus.rdata_o, 32'h00BB_00DD);
        rd(c_IDX_COUNT); check("be_count", bus.rdata_o, 32'h00BB_00DD);
        wr(3'd7, 4'hF, 32'hFFFF_FFFF);
        rd(3'd7);        check("idx7_read", bus.rdata_o, 32'd0);
        rd(3'd5);        check("idx5_read", bus.rdata_o, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r     = $urandom_range(0, 99);
            s_rst = (r < 2);
            s_req = ($urandom_range(0, 9) < 6);
            s_we  = $urandom_range(0, 1);
            s_idx = 3'($urandom_range(0, 7));
            s_be  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            s_fin = ($urandom_range(0, 9) == 0);
            case (s_idx)
                c_IDX_LOAD, c_IDX_COUNT: s_wd = 32'($urandom_range(0, 6));
                c_IDX_PRESCALE:          s_wd = 32'($urandom_range(0, 3));
                c_IDX_CTRL:              s_wd = ($urandom_range(0, 3) != 0) ? 32'h7 : $urandom();
                default:                 s_wd = $urandom();
            endcase
            step(s_rst, s_req, s_we, s_idx, s_be, s_wd, s_fin);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
